// File: rtl/usr_shift_ctrl.sv
// Command sequencer for a combinational universal_shift_8bit datapath: owns the working
// register, turns load/shift-N/read commands into per-cycle mode selects, returns result.
module usr_shift_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [WIDTH-1:0] usr_a,
    output logic [1:0]       usr_s,
    input  logic [WIDTH-1:0] usr_p
);

    localparam logic [1:0] OP_SHL  = 2'b00;
    localparam logic [1:0] OP_HOLD = 2'b01;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   reg_q, reg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;

    logic               cmd_ready_q;
    logic               rsp_valid_q;
    logic               busy_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic [WIDTH-1:0]   usr_a_q;
    logic [1:0]         usr_s_q;

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    cnt_d  = cmd_cnt;
                    data_d = cmd_data;
                    if (cmd_op == OP_LOAD)
                        state_d = ST_LOAD;
                    else if (cmd_op != OP_HOLD && cmd_cnt != '0)
                        state_d = ST_SHIFT;
                    else
                        state_d = ST_RESP;
                end
            end
            ST_LOAD: begin
                reg_d   = usr_p;
                state_d = ST_RESP;
            end
            ST_SHIFT: begin
                reg_d = usr_p;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort beats any simultaneous command accept or pending response.
        if (clr) begin
            state_d = ST_IDLE;
            reg_d   = '0;
            cnt_d   = '0;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            reg_q       <= '0;
            cnt_q       <= '0;
            op_q        <= OP_HOLD;
            data_q      <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_data_q  <= '0;
            usr_a_q     <= '0;
            usr_s_q     <= OP_HOLD;
        end else begin
            state_q     <= state_d;
            reg_q       <= reg_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            data_q      <= data_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
            busy_q      <= (state_d != ST_IDLE);
            rsp_data_q  <= reg_d;
            case (state_d)
                ST_LOAD: begin
                    usr_a_q <= data_d;
                    usr_s_q <= OP_LOAD;
                end
                ST_SHIFT: begin
                    usr_a_q <= reg_d;
                    usr_s_q <= (op_d == OP_SHR) ? OP_SHR : OP_SHL;
                end
                default: begin
                    usr_a_q <= reg_d;
                    usr_s_q <= OP_HOLD;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;
    assign rsp_data  = rsp_data_q;
    assign usr_a     = usr_a_q;
    assign usr_s     = usr_s_q;

endmodule
